pipe_hybrid_sub: RTL

- Two-stage pipelined 32-bit subtractor, the inverse operation of the hybrid 32-bit adder.
- Stage 1 subtracts the low 16 bits and registers the borrow. Stage 2 subtracts the high 16 bits using that registered borrow.
- Valid/ready handshake on both sides, so it drops into streaming datapaths (ALU or DSP accumulate-subtract paths) alongside the hybrid adder.

---
 rtl/pipe_hybrid_sub.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipe_hybrid_sub.sv
// Two-stage pipelined WIDTH-bit subtractor: low half and its borrow in stage 1, high half in stage 2.
// Optional saturate-at-zero on unsigned underflow when PIPE_HYBRID_SUB_SAT_EN is defined.
module pipe_hybrid_sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
`ifdef PIPE_HYBRID_SUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int HALF = WIDTH / 2;

  // Stage 1 registers
  logic            s1_valid_q, s1_valid_d;
  logic [HALF-1:0] low_diff_q, low_diff_d;
  logic            low_borrow_q, low_borrow_d;
  logic [HALF-1:0] a_hi_q, a_hi_d;
  logic [HALF-1:0] b_hi_q, b_hi_d;
  logic            sat_q, sat_d;

  // Stage 2 registers
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Handshake
  logic s2_can_load;
  logic s1_adv;
  logic in_xfer;
  logic out_xfer;

  // Datapath intermediates
  logic [HALF:0]    low_ext;
  logic [HALF:0]    hi_ext;
  logic [HALF-1:0]  hi;
  logic [WIDTH-1:0] raw_d;
  logic             hi_borrow;
  logic             sat_hit;

  always_comb begin
    s2_can_load = !s2_valid_q || out_ready;
    s1_adv      = s1_valid_q && s2_can_load;
    in_ready    = !s1_valid_q || s2_can_load;
    in_xfer     = in_valid && in_ready;
    out_xfer    = s2_valid_q && out_ready;
  end

  // Stage 1: low-half subtract, capture the high halves untouched
  always_comb begin
    low_ext = {1'b0, a[HALF-1:0]} - {1'b0, b[HALF-1:0]} - {{HALF{1'b0}}, bin};

    s1_valid_d   = s1_valid_q;
    low_diff_d   = low_diff_q;
    low_borrow_d = low_borrow_q;
    a_hi_d       = a_hi_q;
    b_hi_d       = b_hi_q;
    sat_d        = sat_q;

    if (in_xfer) begin
      s1_valid_d   = 1'b1;
      low_diff_d   = low_ext[HALF-1:0];
      low_borrow_d = low_ext[HALF];
      a_hi_d       = a[WIDTH-1:HALF];
      b_hi_d       = b[WIDTH-1:HALF];
`ifdef PIPE_HYBRID_SUB_SAT_EN
      sat_d        = sat;
`else
      sat_d        = 1'b0;
`endif
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: high-half subtract with the registered borrow, derive flags
  always_comb begin
    hi_ext    = {1'b0, a_hi_q} - {1'b0, b_hi_q} - {{HALF{1'b0}}, low_borrow_q};
    hi        = hi_ext[HALF-1:0];
    hi_borrow = hi_ext[HALF];
    raw_d     = {hi, low_diff_q};
    sat_hit   = sat_q && hi_borrow;

    s2_valid_d = s2_valid_q;
    d_d        = d_q;
    bout_d     = bout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      bout_d     = hi_borrow;
      ovf_d      = (a_hi_q[HALF-1] != b_hi_q[HALF-1]) && (hi[HALF-1] != a_hi_q[HALF-1]);
      // Saturation only clamps the value; bout/ovf keep reporting the raw result
      d_d        = sat_hit ? '0 : raw_d;
      zero_d     = sat_hit ? 1'b1 : (raw_d == '0);
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      low_diff_q   <= '0;
      low_borrow_q <= 1'b0;
      a_hi_q       <= '0;
      b_hi_q       <= '0;
      sat_q        <= 1'b0;
      s2_valid_q   <= 1'b0;
      d_q          <= '0;
      bout_q       <= 1'b0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      low_diff_q   <= low_diff_d;
      low_borrow_q <= low_borrow_d;
      a_hi_q       <= a_hi_d;
      b_hi_q       <= b_hi_d;
      sat_q        <= sat_d;
      s2_valid_q   <= s2_valid_d;
      d_q          <= d_d;
      bout_q       <= bout_d;
      ovf_q        <= ovf_d;
      zero_q       <= zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign d         = d_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
